// File: rtl/neuron_accumulate_activate.sv
// Accumulates CHUNKS_PER_NEURON signed partial dot-products, adds the neuron bias and
// emits a saturating ReLU activation on a valid/ready output.
module neuron_accumulate_activate #(
    parameter int SUM_WIDTH         = 16,
    parameter int ACC_WIDTH         = 32,
    parameter int OUT_WIDTH         = 16,
    parameter int CHUNKS_PER_NEURON = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [SUM_WIDTH-1:0] partial_sum_in,
    input  logic                 partial_valid_in,
    output logic                 partial_ready_out,
    input  logic [SUM_WIDTH-1:0] bias_in,
    output logic [OUT_WIDTH-1:0] result_out,
    output logic                 result_valid_out,
    input  logic                 result_ready_in,
    output logic                 overflow_out
);

    localparam int CNT_WIDTH = (CHUNKS_PER_NEURON > 1) ? $clog2(CHUNKS_PER_NEURON) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CHUNK = CNT_WIDTH'(CHUNKS_PER_NEURON - 1);
    localparam logic signed [ACC_WIDTH-1:0] POS_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    if (CHUNKS_PER_NEURON < 1 || CHUNKS_PER_NEURON > 256) begin : g_chunks_check
        $error("CHUNKS_PER_NEURON must be in 1..256");
    end
    if (ACC_WIDTH < SUM_WIDTH + $clog2(CHUNKS_PER_NEURON) + 2) begin : g_acc_width_check
        $error("ACC_WIDTH too narrow for an exact sum of partials plus bias");
    end
    if (OUT_WIDTH >= ACC_WIDTH) begin : g_out_width_check
        $error("OUT_WIDTH must be narrower than ACC_WIDTH");
    end

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FINISH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                        state_reg, state_next;
    logic signed [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_WIDTH-1:0]          chunk_cnt_reg, chunk_cnt_next;
    logic [SUM_WIDTH-1:0]          bias_reg, bias_next;
    logic [OUT_WIDTH-1:0]          result_reg, result_next;
    logic                          result_valid_reg, result_valid_next;
    logic                          overflow_reg, overflow_next;

    logic signed [ACC_WIDTH-1:0]   partial_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   total;

    // Sign-extend the incoming partial and the held bias to accumulator width.
    for (genvar gi = 0; gi < ACC_WIDTH; gi++) begin : g_sext
        if (gi < SUM_WIDTH) begin : g_copy
            assign partial_ext[gi] = partial_sum_in[gi];
            assign bias_ext[gi]    = bias_reg[gi];
        end else begin : g_sign
            assign partial_ext[gi] = partial_sum_in[SUM_WIDTH-1];
            assign bias_ext[gi]    = bias_reg[SUM_WIDTH-1];
        end
    end

    assign total = acc_reg + bias_ext;

    always_comb begin
        state_next        = state_reg;
        acc_next          = acc_reg;
        chunk_cnt_next    = chunk_cnt_reg;
        bias_next         = bias_reg;
        result_next       = result_reg;
        result_valid_next = result_valid_reg;
        overflow_next     = overflow_reg;
        case (state_reg)
            ACCUM: begin
                if (partial_valid_in) begin
                    chunk_cnt_next = chunk_cnt_reg + 1'b1;
                    // The first chunk restarts the sum and captures this neuron's bias.
                    if (chunk_cnt_reg == '0) begin
                        acc_next  = partial_ext;
                        bias_next = bias_in;
                    end else begin
                        acc_next = acc_reg + partial_ext;
                    end
                    if (chunk_cnt_reg == LAST_CHUNK) begin
                        chunk_cnt_next = '0;
                        state_next     = FINISH;
                    end
                end
            end
            FINISH: begin
                if (total[ACC_WIDTH-1]) begin
                    result_next = '0;
                end else if (total > POS_MAX) begin
                    result_next   = OUT_MAX;
                    overflow_next = 1'b1;
                end else begin
                    result_next = total[OUT_WIDTH-1:0];
                end
                result_valid_next = 1'b1;
                state_next        = HOLD;
            end
            HOLD: begin
                if (result_ready_in) begin
                    result_valid_next = 1'b0;
                    overflow_next     = 1'b0;
                    acc_next          = '0;
                    state_next        = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg        <= ACCUM;
            acc_reg          <= '0;
            chunk_cnt_reg    <= '0;
            bias_reg         <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            acc_reg          <= acc_next;
            chunk_cnt_reg    <= chunk_cnt_next;
            bias_reg         <= bias_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            overflow_reg     <= overflow_next;
        end
    end

    assign partial_ready_out = (state_reg == ACCUM);
    assign result_out        = result_reg;
    assign result_valid_out  = result_valid_reg;
    assign overflow_out      = overflow_reg;

endmodule

// File: tb/tb_neuron_accumulate_activate.sv
// Directed bench for neuron_accumulate_activate: a transaction-level neuron model is
// checked against the DUT every cycle, and the collected results against literal values.
module tb_neuron_accumulate_activate;

    localparam int SUM_W  = 16;
    localparam int OUT_W  = 16;
    localparam int CHUNKS = 4;
    localparam longint MAXV = (longint'(1) << (OUT_W - 1)) - 1;

    logic             clk_in;
    logic             rst_in;
    logic [SUM_W-1:0] partial_sum_in;
    logic             partial_valid_in;
    logic             partial_ready_out;
    logic [SUM_W-1:0] bias_in;
    logic [OUT_W-1:0] result_out;
    logic             result_valid_out;
    logic             result_ready_in;
    logic             overflow_out;

    neuron_accumulate_activate #(
        .SUM_WIDTH(SUM_W), .ACC_WIDTH(32), .OUT_WIDTH(OUT_W), .CHUNKS_PER_NEURON(CHUNKS)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .partial_sum_in(partial_sum_in), .partial_valid_in(partial_valid_in),
        .partial_ready_out(partial_ready_out), .bias_in(bias_in),
        .result_out(result_out), .result_valid_out(result_valid_out),
        .result_ready_in(result_ready_in), .overflow_out(overflow_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: partials of the neuron in progress, pending results, and where the block
    // is in its output cycle (0 = taking partials, 1 = computing, 2 = presenting).
    longint m_parts[$];
    longint m_bias;
    longint exp_res[$];
    bit     exp_ovf[$];
    int     m_stage    = 0;
    bit     just_reset = 0;
    longint got_res[$];
    bit     got_ovf[$];
    bit     gap_en     = 0;

    initial begin
        forever begin
            @(posedge clk_in);
            if (rst_in) begin
                m_parts.delete();
                exp_res.delete();
                exp_ovf.delete();
                m_stage    = 0;
                just_reset = 1;
            end else begin
                just_reset = 0;
                if (m_stage == 2) begin
                    if (result_ready_in) begin
                        void'(exp_res.pop_front());
                        void'(exp_ovf.pop_front());
                        m_stage = 0;
                    end
                end else if (m_stage == 1) begin
                    m_stage = 2;
                end else if (partial_valid_in) begin
                    if (m_parts.size() == 0) m_bias = longint'($signed(bias_in));
                    m_parts.push_back(longint'($signed(partial_sum_in)));
                    if (m_parts.size() == CHUNKS) begin
                        longint t;
                        t = m_bias;
                        foreach (m_parts[k]) t += m_parts[k];
                        if (t < 0) begin
                            exp_res.push_back(0);   exp_ovf.push_back(1'b0);
                        end else if (t > MAXV) begin
                            exp_res.push_back(MAXV); exp_ovf.push_back(1'b1);
                        end else begin
                            exp_res.push_back(t);   exp_ovf.push_back(1'b0);
                        end
                        m_parts.delete();
                        m_stage = 1;
                    end
                end
            end
        end
    end

    initial begin
        bit     prev_valid = 0;
        bit     prev_rdy   = 0;
        longint prev_res   = 0;
        bit     prev_ovf   = 0;
        int     gap_cnt    = 0;
        forever begin
            @(negedge clk_in);
            chk("partial_ready", partial_ready_out, (m_stage == 0) ? 1 : 0);
            chk("result_valid", result_valid_out, (m_stage == 2) ? 1 : 0);
            if (just_reset) begin
                chk("reset_result", result_out, 0);
                chk("reset_overflow", overflow_out, 0);
            end
            if (m_stage == 2 && exp_res.size() > 0) begin
                chk("result_value", result_out, exp_res[0]);
                chk("overflow_flag", overflow_out, exp_ovf[0]);
            end
            if (prev_valid && !prev_rdy && result_valid_out && !just_reset) begin
                chk("hold_stable_result", result_out, prev_res);
                chk("hold_stable_overflow", overflow_out, prev_ovf);
            end
            if (gap_en) begin
                if (!partial_ready_out) gap_cnt++;
                else if (gap_cnt > 0) begin
                    chk("ready_gap_cycles", gap_cnt, 2);
                    gap_cnt = 0;
                end
            end else gap_cnt = 0;
            if (result_valid_out && result_ready_in && !rst_in) begin
                got_res.push_back(longint'(result_out));
                got_ovf.push_back(overflow_out);
                $display("result %0d overflow %0d at t=%0t", result_out, overflow_out, $time);
            end
            prev_valid = result_valid_out;
            prev_rdy   = result_ready_in;
            prev_res   = longint'(result_out);
            prev_ovf   = overflow_out;
        end
    end

    // Leaves partial_valid_in high so consecutive calls stream back to back.
    task automatic send_partial(input int v, input int b);
        bit h;
        partial_sum_in   = SUM_W'(v);
        bias_in          = SUM_W'(b);
        partial_valid_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            h = partial_ready_out;
            @(posedge clk_in); #1;
            if (h) begin
                $display("partial %0d bias %0d accepted at t=%0t", v, b, $time);
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic send_neuron(input int a, input int b, input int c, input int d, input int bias);
        send_partial(a, bias);
        send_partial(b, bias);
        send_partial(c, bias);
        send_partial(d, bias);
    endtask

    task automatic idle(input int n);
        partial_valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 50; i++) begin
            if (got_res.size() >= n) return;
            @(posedge clk_in); #1;
        end
        chk("result_timeout", got_res.size(), n);
    endtask

    initial begin
        longint lit_res[11] = '{105, 0, 0, 32767, 4, 990, 10, 6, 20, 6, 0};
        bit     lit_ovf[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        rst_in           = 1'b1;
        partial_sum_in   = '0;
        partial_valid_in = 1'b0;
        bias_in          = '0;
        result_ready_in  = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        idle(1);

        send_neuron(10, 20, 30, 40, 5);
        idle(4);  wait_results(1);
        send_neuron(-100, -1, 0, 50, 0);
        idle(4);  wait_results(2);
        send_neuron(-3, 0, 0, 0, 3);
        idle(4);  wait_results(3);
        send_neuron(32767, 32767, 32767, 32767, 32767);
        idle(4);  wait_results(4);
        send_neuron(1, 1, 1, 1, 0);
        idle(4);  wait_results(5);

        // Downstream stalls while an unwanted partial is offered during HOLD.
        result_ready_in = 1'b0;
        send_neuron(100, 200, 300, 400, -10);
        partial_sum_in   = SUM_W'(999);
        partial_valid_in = 1'b1;
        repeat (7) begin
            @(posedge clk_in); #1;
        end
        chk("stall_ready_low", partial_ready_out, 0);
        partial_valid_in = 1'b0;
        result_ready_in  = 1'b1;
        idle(2);  wait_results(6);
        send_neuron(1, 2, 3, 4, 0);
        idle(4);  wait_results(7);

        // Reset in the middle of a neuron throws the partials away.
        send_partial(7, 9);
        send_partial(8, 9);
        partial_valid_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        idle(2);
        send_neuron(1, 1, 1, 1, 2);
        idle(4);  wait_results(8);

        // Continuous stream of three neurons.
        gap_en = 1'b1;
        send_neuron(5, 5, 5, 5, 0);
        send_neuron(-1, -1, -1, -1, 10);
        send_neuron(1000, 1000, 1000, 1000, -4000);
        idle(6);  wait_results(11);
        gap_en = 1'b0;
        idle(2);

        chk("result_count", got_res.size(), 11);
        for (int i = 0; i < 11 && i < got_res.size(); i++) begin
            chk($sformatf("literal_result[%0d]", i), got_res[i], lit_res[i]);
            chk($sformatf("literal_overflow[%0d]", i), got_ovf[i], lit_ovf[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before t=200000");
        $fatal(1, "watchdog expired");
    end

endmodule
